// File: rtl/interp_pkg.sv
// Shared types and defaults for the interpolator line feeder.
package interp_pkg;

  localparam int unsigned DefWidth  = 16;
  localparam int unsigned DefHeight = 16;
  localparam int unsigned DefPadL   = 7;
  localparam int unsigned DefPadR   = 6;

  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDone
  } feeder_state_e;

endpackage

// File: rtl/interp_frame_store.sv
// Single-write, single-read frame store. No reset: contents are undefined until written.
module interp_frame_store
  import interp_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clock,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  pixel_t        i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output pixel_t        o_rd_data
);

  pixel_t r_mem [DEPTH];

  // Synchronous write port.
  always_ff @(posedge clock) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Asynchronous read; the feeder registers the result into pix_out.
  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/interp_line_feeder.sv
// Streams a stored frame line by line (rows, or columns when INTERP_FEEDER_COL_MODE_EN is
// defined) with PAD_L/PAD_R edge replication, and flags which raster sample each beat
// completes. Without INTERP_FEEDER_COL_MODE_EN, col_mode is ignored.
module interp_line_feeder
  import interp_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned HEIGHT = DefHeight,
  parameter int unsigned PAD_L  = DefPadL,
  parameter int unsigned PAD_R  = DefPadR
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            wr_en,
  input  logic [$clog2(WIDTH*HEIGHT)-1:0] wr_addr,
  input  logic [7:0]                      wr_data,
  input  logic                            start,
  input  logic                            col_mode,
  input  logic                            hold,
  output logic [7:0]                      pix_out,
  output logic                            pix_valid,
  output logic                            sample_valid,
  output logic [$clog2(WIDTH*HEIGHT)-1:0] sample_idx,
  output logic                            busy,
  output logic                            done
);

  localparam int unsigned AW   = $clog2(WIDTH * HEIGHT);
  localparam int unsigned NMAX = (WIDTH > HEIGHT) ? WIDTH : HEIGHT;
  localparam int unsigned KW   = $clog2(PAD_L + NMAX + PAD_R + 1);
  localparam int unsigned IW   = $clog2(NMAX + 1);

  feeder_state_e r_state, w_state_nxt;
  logic [KW-1:0] r_beat, w_beat_nxt;   // next beat to issue within the line
  logic [IW-1:0] r_line, w_line_nxt;   // next line to issue; == line count once all issued
  logic          r_col, w_col_nxt;
  pixel_t        r_pix, w_pix_nxt;
  logic          r_pv, w_pv_nxt;
  logic          r_sv, w_sv_nxt;
  logic [AW-1:0] r_sidx, w_sidx_nxt;

  logic          w_col_start, w_col, w_we, w_issue;
  logic [AW-1:0] w_rd_addr;
  pixel_t        w_rd_data;
  int unsigned   w_n, w_lines, w_k, w_i, w_j, w_sj;
  logic          w_sv, w_last_beat, w_all_issued;
  logic [AW-1:0] w_sidx;

`ifdef INTERP_FEEDER_COL_MODE_EN
  assign w_col_start = col_mode;
`else
  logic w_unused_col_mode;
  assign w_unused_col_mode = col_mode;
  assign w_col_start       = 1'b0;
`endif

  // In IDLE the first beat is issued with the mode presented alongside start.
  assign w_col = (r_state == StIdle) ? w_col_start : r_col;
  assign w_we  = wr_en && (r_state == StIdle);

  interp_frame_store #(
    .DEPTH (WIDTH * HEIGHT),
    .AW    (AW)
  ) u_store (
    .clock     (clock),
    .i_wr_en   (w_we),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // Decode the current (line, beat) into a read address and sample index.
  always_comb begin
    w_n     = w_col ? HEIGHT : WIDTH;
    w_lines = w_col ? WIDTH : HEIGHT;
    w_k     = 32'(r_beat);
    w_i     = 32'(r_line);
    if (w_k < PAD_L) begin
      w_j = 0;
    end else if (w_k < PAD_L + w_n) begin
      w_j = w_k - PAD_L;
    end else begin
      w_j = w_n - 1;
    end
    w_sv         = (w_k >= PAD_L + PAD_R);
    w_sj         = w_sv ? (w_k - PAD_L - PAD_R) : 0;
    w_rd_addr    = w_col ? AW'(w_j * WIDTH + w_i) : AW'(w_i * WIDTH + w_j);
    w_sidx       = w_col ? AW'(w_sj * WIDTH + w_i) : AW'(w_i * WIDTH + w_sj);
    w_last_beat  = (w_k == PAD_L + w_n + PAD_R - 1);
    w_all_issued = (w_i >= w_lines);
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_line_nxt  = r_line;
    w_col_nxt   = r_col;
    w_pix_nxt   = r_pix;
    w_pv_nxt    = 1'b0;
    w_sv_nxt    = 1'b0;
    w_sidx_nxt  = r_sidx;
    w_issue     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_nxt = StStream;
          w_col_nxt   = w_col_start;
          w_issue     = 1'b1;
        end
      end
      StStream: begin
        // One cycle after the final beat: leave, whatever hold says.
        if (w_all_issued) begin
          w_state_nxt = StDone;
          w_beat_nxt  = '0;
          w_line_nxt  = '0;
        end else if (!hold) begin
          w_issue = 1'b1;
        end
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
    if (w_issue) begin
      w_pix_nxt = w_rd_data;
      w_pv_nxt  = 1'b1;
      w_sv_nxt  = w_sv;
      if (w_sv) begin
        w_sidx_nxt = w_sidx;
      end
      if (w_last_beat) begin
        w_beat_nxt = '0;
        w_line_nxt = r_line + IW'(1);
      end else begin
        w_beat_nxt = r_beat + KW'(1);
      end
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_beat  <= '0;
      r_line  <= '0;
      r_col   <= 1'b0;
      r_pix   <= '0;
      r_pv    <= 1'b0;
      r_sv    <= 1'b0;
      r_sidx  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      r_line  <= w_line_nxt;
      r_col   <= w_col_nxt;
      r_pix   <= w_pix_nxt;
      r_pv    <= w_pv_nxt;
      r_sv    <= w_sv_nxt;
      r_sidx  <= w_sidx_nxt;
    end
  end

  assign pix_out      = r_pix;
  assign pix_valid    = r_pv;
  assign sample_valid = r_sv;
  assign sample_idx   = r_sidx;
  assign busy         = (r_state == StStream);
  assign done         = (r_state == StDone);

endmodule

// File: tb/tb_interp_line_feeder.sv
// Self-checking bench for interp_line_feeder: a table of frame runs plus hand-written
// reset-abort and idle-write sequences; every beat is checked against a scoreboard.
module tb_interp_line_feeder;
  import interp_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned H  = 16;
  localparam int unsigned PL = 7;
  localparam int unsigned PR = 6;
  localparam int unsigned AW = $clog2(W * H);
`ifdef INTERP_FEEDER_COL_MODE_EN
  localparam bit ColEn = 1'b1;
`else
  localparam bit ColEn = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic          start = 1'b0;
  logic          col_mode = 1'b0;
  logic          hold = 1'b0;
  logic [7:0]    pix_out;
  logic          pix_valid, sample_valid, busy, done;
  logic [AW-1:0] sample_idx;

  interp_line_feeder #(
    .WIDTH  (W),
    .HEIGHT (H),
    .PAD_L  (PL),
    .PAD_R  (PR)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .start        (start),
    .col_mode     (col_mode),
    .hold         (hold),
    .pix_out      (pix_out),
    .pix_valid    (pix_valid),
    .sample_valid (sample_valid),
    .sample_idx   (sample_idx),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0]    pix;
    logic          sv;
    logic [AW-1:0] sidx;
  } beat_t;

  typedef struct {
    logic col;
    int   hold_at;
    int   hold_len;
    int   poke_at;
    int   probe_beat;
    int   exp_probe;
    int   exp_done;
  } vec_t;

  beat_t      sb_q[$];
  logic [7:0] model_mem [W*H];
  vec_t       tbl [9];
  int         n_vec = 0;
  int         n_err = 0;

  function automatic void check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endfunction

  function automatic int raster(input logic c, input int i, input int j);
    return c ? (j * W + i) : (i * W + j);
  endfunction

  function automatic void push_beat(input logic c, input int i, input int j, input int k);
    beat_t b;
    b.pix  = model_mem[raster(c, i, j)];
    b.sv   = (k >= PL + PR);
    b.sidx = b.sv ? AW'(raster(c, i, k - PL - PR)) : '0;
    sb_q.push_back(b);
  endfunction

  // Expected beats of one frame: PL copies of the first pixel, the line, PR copies of the last.
  function automatic void push_frame(input logic col);
    logic c;
    int   n, lines, k;
    c     = col & ColEn;
    n     = c ? H : W;
    lines = c ? W : H;
    for (int i = 0; i < lines; i++) begin
      k = 0;
      for (int p = 0; p < PL; p++) begin push_beat(c, i, 0, k); k++; end
      for (int j = 0; j < n; j++) begin push_beat(c, i, j, k); k++; end
      for (int p = 0; p < PR; p++) begin push_beat(c, i, n - 1, k); k++; end
    end
  endfunction

  // Scoreboard: every live beat is popped and compared.
  always @(posedge clock) begin : monitor
    beat_t         e;
    logic [AW-1:0] sidx_m;
    #1;
    if (pix_valid) begin
      sidx_m = sample_valid ? sample_idx : AW'(0);
      if (sb_q.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("beat{pix,sv,sidx}", int'({pix_out, sample_valid, sidx_m}), int'(e));
      end
    end
  end

  task automatic write_pix(input int addr, input int val);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = 8'(val);
    @(posedge clock); #1;
    wr_en = 1'b0;
    model_mem[addr] = 8'(val);
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    int cyc, held, n_valid, n_sv, probe, done_cyc;
    done_cyc = -1; n_valid = 0; n_sv = 0; probe = -1; held = 0;
    push_frame(v.col);
    start = 1'b1; col_mode = v.col;
    @(posedge clock); #1;
    start = 1'b0; col_mode = 1'b0;
    cyc = 1;
    while (cyc < 2000) begin
      if (start || wr_en) begin start = 1'b0; wr_en = 1'b0; col_mode = 1'b0; end
      if (hold) begin
        held++;
        if (held == v.hold_len) hold = 1'b0;
      end
      if (pix_valid) begin
        if (n_valid == v.probe_beat) probe = int'(pix_out);
        n_valid++;
        if (sample_valid) n_sv++;
        if (v.hold_len > 0 && n_valid == v.hold_at) hold = 1'b1;
        if (n_valid == v.poke_at) begin
          // Illegal-while-streaming requests: must be dropped.
          wr_en = 1'b1; wr_addr = AW'(5); wr_data = 8'hAA; start = 1'b1; col_mode = 1'b1;
        end
      end
      if (done) begin done_cyc = cyc; break; end
      @(posedge clock); #1;
      cyc++;
    end
    hold = 1'b0; start = 1'b0; wr_en = 1'b0;
    check($sformatf("v%0d_done_cycle", idx), done_cyc, v.exp_done);
    check($sformatf("v%0d_valid_beats", idx), n_valid, int'((PL + W + PR) * H));
    check($sformatf("v%0d_sample_beats", idx), n_sv, int'(W * H));
    check($sformatf("v%0d_probe", idx), probe, v.exp_probe);
    // A start presented during DONE is dropped.
    start = 1'b1; col_mode = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; col_mode = 1'b0;
    check($sformatf("v%0d_done_width", idx), int'(done), 0);
    check($sformatf("v%0d_start_in_done", idx), int'(busy), 0);
    @(posedge clock); #1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int quiet;
    //           col   hold_at len poke probe exp_probe                  done
    tbl[0] = '{1'b0, 0,  0, -1,  6,  0,                        465};
    tbl[1] = '{1'b0, 0,  0, -1,  8,  1,                        465};
    tbl[2] = '{1'b0, 0,  0, -1, 22,  15,                       465};
    tbl[3] = '{1'b0, 0,  0, -1, 28,  15,                       465};
    tbl[4] = '{1'b1, 0,  0, -1, 65,  ColEn ? 2 : 32,           465};
    tbl[5] = '{1'b1, 0,  0, -1, 80,  ColEn ? 242 : 47,         465};
    tbl[6] = '{1'b1, 0,  0, -1, 86,  ColEn ? 242 : 47,         465};
    tbl[7] = '{1'b0, 10, 5, 50, 10,  3,                        470};
    tbl[8] = '{1'b0, 0,  0, -1, 12,  5,                        465};

    #12;
    check("rst_pix_out", int'(pix_out), 0);
    check("rst_pix_valid", int'(pix_valid), 0);
    check("rst_sample_valid", int'(sample_valid), 0);
    check("rst_sample_idx", int'(sample_idx), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    for (int a = 0; a < int'(W * H); a++) write_pix(a, a);

    for (int v = 0; v < 9; v++) run_frame(tbl[v], v);

    // Reset at beat 100 aborts the stream with no done pulse.
    push_frame(1'b0);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (100) begin @(posedge clock); #1; end
    check("beat100_valid", int'(pix_valid), 1);
    check("beat100_pix", int'(pix_out), 54);
    reset = 1'b1;
    #1;
    check("abort_pix_out", int'(pix_out), 0);
    check("abort_pix_valid", int'(pix_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_sample_idx", int'(sample_idx), 0);
    sb_q.delete();
    repeat (2) begin @(posedge clock); #1; end
    reset = 1'b0;
    quiet = 0;
    repeat (600) begin
      @(posedge clock); #1;
      if (done || busy || pix_valid) quiet++;
    end
    check("abort_no_activity", quiet, 0);
    run_frame('{1'b0, 0, 0, -1, 0, 0, 465}, 9);

    // A write in IDLE is honoured.
    write_pix(5, 8'hAA);
    run_frame('{1'b0, 0, 0, -1, 12, 170, 465}, 10);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
